gpio_input_capture: RTL



---
 rtl/gpio_pkg.sv | 27 ++
 rtl/gpio_input_capture_if.sv | 21 ++
 rtl/gpio_debounce_bit.sv | 55 +++++
 rtl/gpio_input_capture.sv | 93 +++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - shared constants and helpers for the GPIO input capture block
// Contents: register word addresses, edge-mode encodings, per-bit edge qualifier.
package gpio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  // True when the prev->cur transition of one debounced bit is an edge of the selected kind.
  function automatic logic edge_hit(input logic prev, input logic cur, input edge_mode_e mode);
    logic hit;
    case (mode)
      EDGE_RISE: hit = ~prev & cur;
      EDGE_FALL: hit = prev & ~cur;
      default:   hit = prev ^ cur;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/gpio_input_capture_if.sv
// rtl/gpio_input_capture_if.sv - Avalon-MM slave register bus plus level IRQ
// Signals: address (word), read/write strobes, writedata, registered readdata, irq.
// master: the Nios II side; slave: gpio_input_capture.
interface gpio_input_capture_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, read, write, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/gpio_debounce_bit.sv
// rtl/gpio_debounce_bit.sv - single-bit 2-flop synchronizer and debounce filter
// Ports: clk_i clock, reset_i sync active-high reset, pin_i raw async input,
//        stable_o debounced level (changes 2 + DEBOUNCE_CYCLES cycles after a clean pin change).
module gpio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic stable_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The counter measures how long sync2 has disagreed with stable; any agreement restarts it,
  // so a glitch shorter than DEBOUNCE_CYCLES can never move stable.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= IDLE_LEVEL;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/gpio_input_capture.sv
// rtl/gpio_input_capture.sv - debounced GPIO inputs with sticky edge capture and level IRQ
// Ports: CLOCK_50 clock, reset sync active-high, pins_in raw board inputs,
//        avs Avalon-MM slave (data@0, reserved@1, irq_mask@2, edge_capture@3 W1C, irq),
//        debounced_out debounced levels for local fabric.
import gpio_pkg::*;

module gpio_input_capture #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_MODE       = 1,
  parameter bit IDLE_LEVEL      = 1'b1
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     pins_in,
  gpio_input_capture_if.slave  avs,
  output logic [WIDTH-1:0]     debounced_out
);

  localparam logic [1:0] MODE_BITS = EDGE_MODE[1:0];
  localparam edge_mode_e MODE      = edge_mode_e'(MODE_BITS);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_prev_q;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_d;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] mask_d;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;
  logic             irq_q;
  logic             irq_d;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_debounce (
      .clk_i    (CLOCK_50),
      .reset_i  (reset),
      .pin_i    (pins_in[g]),
      .stable_o (stable[g])
    );
    assign edge_pulse[g] = edge_hit(stable_prev_q[g], stable[g], MODE);
  end

  always_comb begin
    w1c     = '0;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    if (avs.write && (avs.address == ADDR_EDGE)) begin
      w1c = avs.writedata[WIDTH-1:0];
    end
    if (avs.write && (avs.address == ADDR_MASK)) begin
      mask_d = avs.writedata[WIDTH-1:0];
    end
    // OR-ing the pulse in after the clear makes a same-cycle edge win over W1C.
    edge_d = (edge_q & ~w1c) | edge_pulse;
    irq_d  = |(edge_q & mask_q);
    // Reads sample the current registers, so a same-cycle write is not yet visible.
    if (avs.read) begin
      case (avs.address)
        ADDR_DATA: rdata_d = 32'(stable);
        ADDR_MASK: rdata_d = 32'(mask_q);
        ADDR_EDGE: rdata_d = 32'(edge_q);
        default:   rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      stable_prev_q <= {WIDTH{IDLE_LEVEL}};
      edge_q        <= '0;
      mask_q        <= '0;
      rdata_q       <= '0;
      irq_q         <= 1'b0;
    end else begin
      stable_prev_q <= stable;
      edge_q        <= edge_d;
      mask_q        <= mask_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
    end
  end

  assign avs.readdata  = rdata_q;
  assign avs.irq       = irq_q;
  assign debounced_out = stable;

endmodule
